// File: rtl/booth_pkg.sv
// Package: booth_pkg
// Shared types for the radix-4 Booth sequential multiplier.
//   state_t       : control FSM states (IDLE, CALC, DONE)
//   booth_digit_t : one recoded Booth digit as {neg, one, two} flags
//   booth_decode  : overlapping bit triple {b[2c+1], b[2c], b[2c-1]} -> digit
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Digit value = (neg ? -1 : +1) * (two ? 2 : one ? 1 : 0).
    typedef struct packed {
        logic neg;
        logic one;
        logic two;
    } booth_digit_t;

    // Triples 000 and 111 both mean zero. neg is cleared for 111 so a zero
    // digit never requests a negation of the multiplicand.
    function automatic booth_digit_t booth_decode(input logic [2:0] triple);
        booth_digit_t d;
        d.neg = triple[2] & ~(triple[1] & triple[0]);
        d.one = triple[1] ^ triple[0];
        d.two = (triple == 3'b011) || (triple == 3'b100);
        return d;
    endfunction

endpackage

// File: rtl/booth_r4_digit_enc.sv
// Module: booth_r4_digit_enc
// Combinational radix-4 Booth digit encoder.
// Ports:
//   triple : in  3  overlapping multiplier bits {b[2c+1], b[2c], b[2c-1]}
//   neg    : out 1  digit is negative
//   one    : out 1  digit magnitude is 1
//   two    : out 1  digit magnitude is 2
module booth_r4_digit_enc
    import booth_pkg::*;
(
    input  logic [2:0] triple,
    output logic       neg,
    output logic       one,
    output logic       two
);

    booth_digit_t digit;

    assign digit           = booth_decode(triple);
    assign {neg, one, two} = {digit.neg, digit.one, digit.two};

endmodule

// File: rtl/booth_r4_seq_mult.sv
// Module: booth_r4_seq_mult
// Iterative radix-4 Booth multiplier retiring one recoded digit per clock.
// One operation in flight; valid/ready handshake on both sides; the result
// appears exactly WIDTH/2+1 clocks after acceptance and is held until taken.
// Optional feature macro: BOOTH_ACC_EN (adds the acc port; when acc=1 at
// acceptance the new product is added onto the previous p).
// Parameters:
//   WIDTH     : operand width, even and >= 4; product is 2*WIDTH bits
// Ports:
//   clock     : in  1        rising-edge clock
//   reset     : in  1        synchronous active-high reset
//   in_valid  : in  1        a, b, tc (and acc) are valid
//   in_ready  : out 1        block can accept an operation (IDLE)
//   a         : in  WIDTH    multiplicand
//   b         : in  WIDTH    multiplier, Booth-recoded
//   tc        : in  1        1 = two's-complement operands, 0 = unsigned
//   out_valid : out 1        p holds a finished product (DONE)
//   out_ready : in  1        consumer takes p
//   p         : out 2*WIDTH  product (retained after hand-off)
//   busy      : out 1        FSM not in IDLE
//   acc       : in  1        BOOTH_ACC_EN only: accumulate onto previous p
module booth_r4_seq_mult
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               tc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] p,
`ifdef BOOTH_ACC_EN
    output logic               busy,
    input  logic               acc
`else
    output logic               busy
`endif
);

    localparam int ND = WIDTH / 2 + 1;       // number of Booth digits
    localparam int CW = $clog2(ND + 1);      // digit counter width
    localparam int XW = WIDTH + 2;           // extended operand width
    localparam int AW = 2 * WIDTH + 2;       // accumulator width
    localparam int PW = 2 * WIDTH;           // product width

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic [XW-1:0]   a_q;                    // extended multiplicand
    logic [XW:0]     b_q;                    // extended multiplier with b[-1]=0 appended
    logic [AW-1:0]   acc_q;
    logic [PW-1:0]   p_q;

    logic            accept;
    logic            last_digit;
    logic [CW:0]     base;
    logic [2:0]      triple;
    logic            d_neg, d_one, d_two;
    logic [XW:0]     mag;
    logic [XW:0]     pp;
    logic [AW-1:0]   pp_ext;
    logic [AW-1:0]   acc_next;
    logic [AW-1:0]   acc_init;
    logic [XW-1:0]   a_ext;
    logic [XW-1:0]   b_ext;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    assign accept     = (state_q == IDLE) && in_valid;
    assign last_digit = (cnt_q == CW'(ND - 1));

    // NOTE: state and data registers use non-blocking assignments so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output of this block gets a default first so no path
    // leaves a signal unassigned and infers a latch.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_d = CALC;
            end
            CALC: begin
                if (last_digit) state_d = DONE;
            end
            DONE: begin
                // No bypass: a new operation waits for IDLE even when the
                // result is taken this cycle.
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Digit selection and partial product
    // ------------------------------------------------------------------
    // b_q[0] is the implicit b[-1]=0, so digit c lives at b_q[2c+2:2c].
    assign base   = {cnt_q, 1'b0};
    assign triple = b_q[base +: 3];

    booth_r4_digit_enc u_enc (
        .triple (triple),
        .neg    (d_neg),
        .one    (d_one),
        .two    (d_two)
    );

    // Negation is applied to the extended multiplicand (invert + 1) before
    // the positional shift, so the shifted-in zeros are never inverted.
    always_comb begin
        mag = '0;
        if (d_two) begin
            mag = {a_q, 1'b0};
        end else if (d_one) begin
            mag = {a_q[XW-1], a_q};
        end
        pp       = d_neg ? (~mag + 1'b1) : mag;
        pp_ext   = {{(AW - XW - 1){pp[XW]}}, pp};
        acc_next = acc_q + (pp_ext << base);
    end

    // ------------------------------------------------------------------
    // Operand capture and accumulator start value
    // ------------------------------------------------------------------
    assign a_ext = tc ? {{2{a[WIDTH-1]}}, a} : {2'b00, a};
    assign b_ext = tc ? {{2{b[WIDTH-1]}}, b} : {2'b00, b};

`ifdef BOOTH_ACC_EN
    // Extension of the old p only affects the discarded upper bits, but it
    // keeps the accumulator a faithful wide value for the current mode.
    assign acc_init = acc ? {{2{tc & p_q[PW-1]}}, p_q} : '0;
`else
    assign acc_init = '0;
`endif

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    // NOTE: the operand registers are reset along with the rest; the block
    // is small and a clean post-reset state simplifies debug.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
            p_q   <= '0;
        end else if (accept) begin
            cnt_q <= '0;
            a_q   <= a_ext;
            b_q   <= {b_ext, 1'b0};
            acc_q <= acc_init;
        end else if (state_q == CALC) begin
            cnt_q <= cnt_q + 1'b1;
            acc_q <= acc_next;
            if (last_digit) begin
                p_q <= acc_next[PW-1:0];
            end
        end
    end

    assign p = p_q;

endmodule

// File: tb/tb_booth_r4_seq_mult.sv
// Testbench for booth_r4_seq_mult: a WIDTH=8 instance exercised by a
// vector table and hand-written corner sequences, plus a WIDTH=16 instance
// driven with random operands. Expected products enter per-instance
// queues when an operation is accepted and are popped when p is taken.
module tb_booth_r4_seq_mult;

    localparam int ND8 = 8 / 2 + 1;

`ifdef BOOTH_ACC_EN
    localparam bit HAS_ACC = 1'b1;
`else
    localparam bit HAS_ACC = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;

    logic        in_valid8, in_ready8, tc8, out_valid8, out_ready8, busy8, acc8;
    logic [7:0]  a8, b8;
    logic [15:0] p8;

    logic        in_valid16, in_ready16, tc16, out_valid16, out_ready16, busy16, acc16;
    logic [15:0] a16, b16;
    logic [31:0] p16;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    logic [15:0] q8[$];
    logic [31:0] q16[$];
    logic [15:0] last8 = '0;
    logic [31:0] last16 = '0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    booth_r4_seq_mult #(.WIDTH(8)) dut8 (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .a         (a8),
        .b         (b8),
        .tc        (tc8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .p         (p8),
`ifdef BOOTH_ACC_EN
        .busy      (busy8),
        .acc       (acc8)
`else
        .busy      (busy8)
`endif
    );

    booth_r4_seq_mult #(.WIDTH(16)) dut16 (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid16),
        .in_ready  (in_ready16),
        .a         (a16),
        .b         (b16),
        .tc        (tc16),
        .out_valid (out_valid16),
        .out_ready (out_ready16),
        .p         (p16),
`ifdef BOOTH_ACC_EN
        .busy      (busy16),
        .acc       (acc16)
`else
        .busy      (busy16)
`endif
    );

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        tc;
        logic [15:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired (t=%0t)", name, $time);
    endtask

    // Reference product: operands widened to 64-bit integers, optional
    // accumulation onto the previous product, truncated to 2*w bits.
    function automatic logic [31:0] model(input int w, input logic [31:0] x, input logic [31:0] y,
                                          input bit t, input bit ac, input logic [31:0] pold);
        longint xv = longint'(x);
        longint yv = longint'(y);
        longint r;
        if (t && x[w-1]) xv = xv - (64'sd1 <<< w);
        if (t && y[w-1]) yv = yv - (64'sd1 <<< w);
        r = xv * yv;
        if (HAS_ACC && ac) r = r + longint'(pold);
        r = r & ((64'sd1 <<< (2 * w)) - 1);
        return 32'(r);
    endfunction

    // Result monitor for the 8-bit instance: one pop per handshake.
    always @(negedge clock) begin
        if (!reset && out_valid8 && out_ready8) begin
            if (q8.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result8: got 0x%0h with empty queue (t=%0t)", p8, $time);
            end else begin
                check("result8", {16'h0, p8}, {16'h0, q8.pop_front()});
            end
        end
    end

    task automatic do_op(input logic [7:0] ta, input logic [7:0] tb, input bit ttc, input bit tacc,
                         input logic [15:0] texp, input bit push);
        bit got = 1'b0;
        a8 = ta; b8 = tb; tc8 = ttc; acc8 = tacc; in_valid8 = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (in_ready8) begin got = 1'b1; break; end
        end
        if (!got) fail_now("accept8_timeout");
        if (push) begin
            q8.push_back(texp);
            last8 = texp;
        end
        @(posedge clock); #1;
        in_valid8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom);   // operands need not be held
    endtask

    task automatic wait_drain();
        bit done = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clock); #1;
            if (q8.size() == 0 && !busy8) begin done = 1'b1; break; end
        end
        if (!done) fail_now("drain8_timeout");
    endtask

    task automatic op16(input logic [15:0] ta, input logic [15:0] tb, input bit ttc, input bit tacc);
        bit got = 1'b0;
        logic [31:0] e;
        a16 = ta; b16 = tb; tc16 = ttc; acc16 = tacc; in_valid16 = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (in_ready16) begin got = 1'b1; break; end
        end
        if (!got) fail_now("accept16_timeout");
        e = model(16, {16'h0, ta}, {16'h0, tb}, ttc, tacc, last16);
        q16.push_back(e);
        last16 = e;
        @(posedge clock); #1;
        in_valid16 = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (out_valid16) begin got = 1'b1; break; end
        end
        if (!got) fail_now("result16_timeout");
        else check("result16", p16, q16.pop_front());
        @(posedge clock); #1;
    endtask

    initial begin
        vec_t        vecs[$];
        int          acc_cyc[$];
        int          n;
        int          guard;
        logic [7:0]  ra, rb;
        bit          rt, rac;
        logic [15:0] e;
        bit          got;

        vecs.push_back('{8'hFF, 8'hFF, 1'b0, 16'hFE01});
        vecs.push_back('{8'h80, 8'h80, 1'b1, 16'h4000});
        vecs.push_back('{8'h80, 8'h7F, 1'b1, 16'hC080});
        vecs.push_back('{8'hFF, 8'hFF, 1'b1, 16'h0001});
        vecs.push_back('{8'h7F, 8'h7F, 1'b1, 16'h3F01});
        vecs.push_back('{8'hFF, 8'h01, 1'b1, 16'hFFFF});
        vecs.push_back('{8'h80, 8'hFF, 1'b0, 16'h7F80});
        vecs.push_back('{8'h00, 8'h00, 1'b1, 16'h0000});
        vecs.push_back('{8'h0C, 8'hF6, 1'b1, 16'hFF88});
        vecs.push_back('{8'hAA, 8'h55, 1'b0, 16'h3872});

        reset = 1'b1;
        in_valid8 = 1'b0; a8 = '0; b8 = '0; tc8 = 1'b0; acc8 = 1'b0; out_ready8 = 1'b1;
        in_valid16 = 1'b0; a16 = '0; b16 = '0; tc16 = 1'b0; acc16 = 1'b0; out_ready16 = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("rst_in_ready",  {31'h0, in_ready8},  32'h1);
        check("rst_out_valid", {31'h0, out_valid8}, 32'h0);
        check("rst_busy",      {31'h0, busy8},      32'h0);
        check("rst_p",         {16'h0, p8},         32'h0);
        check("rst_p16",       p16,                 32'h0);
        reset = 1'b0;

        // Latency: result exactly ND clocks after acceptance, in_ready low throughout.
        out_ready8 = 1'b0;
        do_op(8'hFF, 8'hFF, 1'b0, 1'b0, 16'hFE01, 1'b1);
        for (int i = 1; i <= ND8; i++) begin
            @(posedge clock); #1;
            check("lat_in_ready",  {31'h0, in_ready8},  32'h0);
            check("lat_out_valid", {31'h0, out_valid8}, (i == ND8) ? 32'h1 : 32'h0);
        end
        out_ready8 = 1'b1;
        wait_drain();

        // Vector table.
        foreach (vecs[i]) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].tc, 1'b0, vecs[i].exp, 1'b1);
            wait_drain();
        end

        // Back-pressure: result held, new requests ignored.
        out_ready8 = 1'b0;
        do_op(8'hFD, 8'h05, 1'b1, 1'b0, 16'hFFF1, 1'b1);
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock); #1;
            if (out_valid8) begin got = 1'b1; break; end
        end
        if (!got) fail_now("stall_out_valid_timeout");
        a8 = 8'h01; b8 = 8'h01; tc8 = 1'b0; in_valid8 = 1'b1;
        repeat (10) begin
            @(posedge clock); #1;
            check("stall_p",         {16'h0, p8},         32'h0000FFF1);
            check("stall_out_valid", {31'h0, out_valid8}, 32'h1);
            check("stall_in_ready",  {31'h0, in_ready8},  32'h0);
        end
        in_valid8 = 1'b0;
        out_ready8 = 1'b1;
        wait_drain();

        // Reset during the second CALC cycle discards the operation.
        do_op(8'h09, 8'h09, 1'b0, 1'b0, 16'h0051, 1'b0);
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        check("midrst_busy",      {31'h0, busy8},      32'h0);
        check("midrst_out_valid", {31'h0, out_valid8}, 32'h0);
        check("midrst_p",         {16'h0, p8},         32'h0);
        check("midrst_in_ready",  {31'h0, in_ready8},  32'h1);
        reset = 1'b0;
        last8 = '0;
        last16 = '0;
        do_op(8'h07, 8'h06, 1'b0, 1'b0, 16'd42, 1'b1);
        wait_drain();

        // Back-to-back: in_valid and out_ready held high.
        out_ready8 = 1'b1;
        acc8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); tc8 = 1'($urandom); in_valid8 = 1'b1;
        n = 0; guard = 0;
        while (n < 6 && guard < 200) begin
            @(negedge clock);
            guard++;
            if (in_ready8) begin
                e = 16'(model(8, {24'h0, a8}, {24'h0, b8}, tc8, 1'b0, {16'h0, last8}));
                q8.push_back(e);
                last8 = e;
                acc_cyc.push_back(cyc);
                n++;
                @(posedge clock); #1;
                a8 = 8'($urandom); b8 = 8'($urandom); tc8 = 1'($urandom);
            end
        end
        in_valid8 = 1'b0;
        if (n < 6) fail_now("b2b_accept_count");
        for (int i = 1; i < acc_cyc.size(); i++)
            check("b2b_spacing", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'(ND8 + 2));
        wait_drain();

`ifdef BOOTH_ACC_EN
        do_op(8'd10, 8'd10, 1'b0, 1'b0, 16'd100, 1'b1);
        wait_drain();
        do_op(8'd3, 8'd4, 1'b0, 1'b1, 16'd112, 1'b1);
        wait_drain();
`endif

        // Random operations against the model, 8-bit instance.
        for (int i = 0; i < 30; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rt = 1'($urandom);
            rac = HAS_ACC ? 1'($urandom) : 1'b0;
            e = 16'(model(8, {24'h0, ra}, {24'h0, rb}, rt, rac, {16'h0, last8}));
            do_op(ra, rb, rt, rac, e, 1'b1);
            wait_drain();
        end

        // 16-bit instance: extremes, then random.
        op16(16'h8000, 16'h8000, 1'b1, 1'b0);
        op16(16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
        op16(16'h8000, 16'h7FFF, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++)
            op16(16'($urandom), 16'($urandom), 1'($urandom), HAS_ACC ? 1'($urandom) : 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish (t=%0t)", $time);
        $fatal(1, "timeout");
    end

endmodule
